// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// First-word-fall-through FIFO. The head byte is presented on o_Data whenever
// o_Data_Valid is high, and the consumer takes it with i_Data_Ready.
// Bytes that arrive while the FIFO is full, and that are not covered by a
// same-cycle pop, are dropped. A dropped byte sets a sticky overflow flag.
// The block also keeps a running count of buffered end-of-line bytes, so that
// consumers can tell when a complete line is waiting.
module uart_rx_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] EOL_BYTE   = 8'h0A
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst_n,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  output logic                  o_Data_Valid,
  output logic [7:0]            o_Data,
  input  logic                  i_Data_Ready,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Overflow,
  input  logic                  i_Clear_Ovf,
  output logic [DEPTH_LOG2:0]   o_Line_Count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Storage and bookkeeping state
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2:0]   line_q, line_d;
  logic                  ovf_q, ovf_d;

  // Per-cycle decode
  logic       full;
  logic       empty;
  logic [7:0] head;
  logic       pop;
  logic       push;
  logic       drop;
  logic       eol_push;
  logic       eol_pop;

  // Status and handshake decode. Flags come from registered state only; the
  // input strobes only qualify the push/pop/drop events.
  always_comb begin
    full     = (count_q == DEPTH_CNT);
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    pop      = !empty && i_Data_Ready;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
    push     = i_RX_DV && (!full || pop);
    drop     = i_RX_DV && full && !pop;
    eol_push = push && (i_RX_Byte == EOL_BYTE);
    eol_pop  = pop && (head == EOL_BYTE);
  end

  // Next-state computation for pointers, occupancy, line count and overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    line_d   = line_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // An EOL entering and another leaving in the same cycle cancel out.
    case ({eol_push, eol_pop})
      2'b10:   line_d = line_q + 1'b1;
      2'b01:   line_d = line_q - 1'b1;
      default: line_d = line_q;
    endcase

    // A drop wins over a same-cycle clear, so a loss is never hidden.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_Clear_Ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control state registers, cleared by the asynchronous reset
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      line_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      line_q   <= line_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage. It has no reset; a cleared count makes old contents invisible.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_RX_Byte;
    end
  end

  assign o_Data_Valid = !empty;
  assign o_Data       = empty ? 8'h00 : head;
  assign o_Count      = count_q;
  assign o_Full       = full;
  assign o_Empty      = empty;
  assign o_Overflow   = ovf_q;
  assign o_Line_Count = line_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;
  localparam logic [7:0] EOL = 8'h0A;

  logic           i_Clock;
  logic           i_Rst_n;
  logic           i_RX_DV;
  logic [7:0]     i_RX_Byte;
  logic           o_Data_Valid;
  logic [7:0]     o_Data;
  logic           i_Data_Ready;
  logic [DL2:0]   o_Count;
  logic           o_Full;
  logic           o_Empty;
  logic           o_Overflow;
  logic           i_Clear_Ovf;
  logic [DL2:0]   o_Line_Count;

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .EOL_BYTE(EOL)) dut (
    .i_Clock      (i_Clock),
    .i_Rst_n      (i_Rst_n),
    .i_RX_DV      (i_RX_DV),
    .i_RX_Byte    (i_RX_Byte),
    .o_Data_Valid (o_Data_Valid),
    .o_Data       (o_Data),
    .i_Data_Ready (i_Data_Ready),
    .o_Count      (o_Count),
    .o_Full       (o_Full),
    .o_Empty      (o_Empty),
    .o_Overflow   (o_Overflow),
    .i_Clear_Ovf  (i_Clear_Ovf),
    .o_Line_Count (o_Line_Count)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       ovf_m;
  logic [7:0] last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_lines();
    int n = 0;
    foreach (sb[i]) if (sb[i] == EOL) n++;
    return n;
  endfunction

  task automatic compare_outputs();
    int n = sb.size();
    check("valid", {31'd0, o_Data_Valid}, (n != 0) ? 32'd1 : 32'd0);
    check("data",  {24'd0, o_Data}, (n != 0) ? {24'd0, sb[0]} : 32'd0);
    check("count", {27'd0, o_Count}, n);
    check("full",  {31'd0, o_Full}, (n == DEPTH) ? 32'd1 : 32'd0);
    check("empty", {31'd0, o_Empty}, (n == 0) ? 32'd1 : 32'd0);
    check("ovf",   {31'd0, o_Overflow}, {31'd0, ovf_m});
    check("lines", {27'd0, o_Line_Count}, model_lines());
  endtask

  // Called just after a falling edge: checks outputs, applies one cycle of stimulus.
  task automatic cycle(input logic dv, input logic [7:0] b, input logic rdy, input logic clr);
    logic pop_m, full_m, push_m;
    i_RX_DV      = dv;
    i_RX_Byte    = b;
    i_Data_Ready = rdy;
    i_Clear_Ovf  = clr;
    #1;
    compare_outputs();
    full_m = (sb.size() == DEPTH);
    pop_m  = (sb.size() != 0) && rdy;
    push_m = dv && (!full_m || pop_m);
    if (pop_m) last_pop = sb.pop_front();
    if (push_m) sb.push_back(b);
    if (dv && full_m && !pop_m) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    @(posedge i_Clock);
    @(negedge i_Clock);
    i_RX_DV      = 1'b0;
    i_RX_Byte    = 8'h00;
    i_Data_Ready = 1'b0;
    i_Clear_Ovf  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'd0, o_Data_Valid}, 32'd0);
    check({tag, "_data"},  {24'd0, o_Data}, 32'd0);
    check({tag, "_count"}, {27'd0, o_Count}, 32'd0);
    check({tag, "_full"},  {31'd0, o_Full}, 32'd0);
    check({tag, "_empty"}, {31'd0, o_Empty}, 32'd1);
    check({tag, "_ovf"},   {31'd0, o_Overflow}, 32'd0);
    check({tag, "_lines"}, {27'd0, o_Line_Count}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    int rst_at;
    i_Rst_n      = 1'b0;
    i_RX_DV      = 1'b0;
    i_RX_Byte    = 8'h00;
    i_Data_Ready = 1'b0;
    i_Clear_Ovf  = 1'b0;
    ovf_m        = 1'b0;
    last_pop     = 8'h00;
    repeat (3) @(negedge i_Clock);
    check_reset_values("rst");
    i_Rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Single byte through
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop41", {24'd0, last_pop}, 32'h41);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_set", {31'd0, o_Overflow}, 32'd1);
    drain();
    check("ovf_held", {31'd0, o_Overflow}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    drain();
    check("aa_last", {24'd0, last_pop}, 32'hAA);

    // Line counting, including a dropped EOL while full
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b0, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    check("lines2", {27'd0, o_Line_Count}, 32'd2);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("lines1", {27'd0, o_Line_Count}, 32'd1);
    while (sb.size() < DEPTH) cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b1, EOL, 1'b0, 1'b0);
    cycle(1'b1, EOL, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("drop_eol", {27'd0, o_Line_Count}, 32'd1);
    drain();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic with wrap, then an asynchronous reset mid-stream
    rst_at = $urandom_range(40, 70);
    for (int i = 0; i < rst_at; i++) begin
      logic dv;
      logic [7:0] b;
      dv = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 5) == 0) ? EOL : 8'($urandom);
      cycle(dv, b, ($urandom_range(0, 1) == 1), 1'b0);
    end
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0, 1'b0);
    #2;
    i_Rst_n = 1'b0;
    #1;
    check_reset_values("arst");
    sb.delete();
    ovf_m = 1'b0;
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("post_rst", {24'd0, last_pop}, 32'h5A);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver on the DE10-Lite. Captures each one-cycle data-valid strobe and byte from the receiver into a first-word-fall-through FIFO. Presents the bytes to the consuming logic over a valid/ready handshake. Also reports fill level, a sticky overflow flag, and the number of complete lines (end-of-line bytes) currently buffered.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default); legal range 1..8.
- EOL_BYTE, 8'h0A: byte value treated as end of line.

Ports (one clock; reset is asynchronous and active-low):
- i_Clock  in  1  system clock (50 MHz).
- i_Rst_n  in  1  asynchronous active-low reset.
- i_RX_DV  in  1  one-cycle strobe from the receiver; the byte is valid in that cycle.
- i_RX_Byte  in  8  received byte, sampled when i_RX_DV=1.
- o_Data_Valid  out  1  head entry available; equals not-empty.
- o_Data  out  8  head byte; forced to 8'h00 when o_Data_Valid=0.
- i_Data_Ready  in  1  consumer accepts the head byte this cycle.
- o_Count  out  DEPTH_LOG2+1  number of stored bytes, 0..2^DEPTH_LOG2.
- o_Full  out  1  o_Count == 2^DEPTH_LOG2.
- o_Empty  out  1  o_Count == 0.
- o_Overflow  out  1  sticky: at least one byte was dropped.
- i_Clear_Ovf  in  1  synchronous clear of o_Overflow.
- o_Line_Count  out  DEPTH_LOG2+1  number of EOL_BYTE entries currently stored.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 memory, write pointer, read pointer, occupancy counter. Pointers are DEPTH_LOG2 bits wide and wrap modulo depth with no special case. Memory contents are not reset.
- Pop: occurs when o_Data_Valid=1 and i_Data_Ready=1. Read pointer advances and count decrements. i_Data_Ready while empty is ignored.
- Push: occurs when i_RX_DV=1 and either (not full) or (a pop occurs in the same cycle). i_RX_Byte is written at the write pointer, the pointer advances, and count increments.
- Simultaneous push and pop: count unchanged. Both pointers advance.
- Full with push and pop in the same cycle: the push is accepted. Full stays asserted.
- Empty with push: the pushed byte is not poppable in the same cycle because o_Data_Valid=0.
- Drop: i_RX_DV=1, full, no pop. The byte is discarded, o_Overflow sets, and count and pointers are unchanged.
- o_Overflow: set on drop, cleared by i_Clear_Ovf. If a drop and a clear happen in the same cycle, set wins.
- o_Line_Count:
  - +1 on an accepted push of EOL_BYTE.
  - -1 on a pop whose head byte equals EOL_BYTE.
  - Both in the same cycle: unchanged.
  - A dropped EOL_BYTE is not counted.
  - Never exceeds o_Count.
- o_Full, o_Empty, o_Data_Valid and o_Data are decoded combinationally from registered state. They have no combinational path from i_RX_DV, i_RX_Byte or i_Data_Ready.

## Timing
- Reset (asynchronous, i_Rst_n=0): pointers=0, o_Count=0, o_Line_Count=0, o_Overflow=0.
  - Hence o_Empty=1, o_Full=0, o_Data_Valid=0, o_Data=8'h00.
  - Reset mid-stream discards all contents, with no partial state.
- Deassertion of i_Rst_n is treated as synchronous to i_Clock by the system.
- Push latency: a byte strobed in cycle N appears on o_Data, with o_Data_Valid=1, from cycle N+1 if the FIFO was empty.
- Pop: the byte accepted in cycle N is replaced by the next entry on o_Data in cycle N+1, or o_Data_Valid falls if that was the last entry.
- Throughput: one push and one pop per cycle sustained. The receiver strobes far slower, at most one byte per CLKS_PER_BIT*10 cycles.
- All state updates occur on the rising edge of i_Clock only.

## Test plan
- Reset then idle: all outputs at their reset values. Push 8'h41 -> next cycle o_Data_Valid=1, o_Data=8'h41, o_Count=1. Pop -> o_Empty=1, o_Data=8'h00.
- Push 8'h00..8'h0F with i_Data_Ready=0 (DEPTH_LOG2=4) -> o_Full=1, o_Count=16. Push 8'hFF -> dropped, o_Overflow=1, o_Count=16. Drain -> 8'h00..8'h0F in order. o_Overflow stays 1 until i_Clear_Ovf pulses.
- Full FIFO, push 8'hAA with i_Data_Ready=1 in the same cycle -> o_Overflow stays 0, o_Count=16, 8'hAA is popped last.
- Push "AB\nC\n" (41 42 0A 43 0A) -> o_Line_Count=2. Pop three bytes -> o_Line_Count=1. A dropped 8'h0A while full -> o_Line_Count unchanged.
- Wrap: 40 push/pop cycles with random gaps and random ready -> output stream equals input stream, o_Count matches the scoreboard every cycle. Assert i_Rst_n=0 at a random cycle -> all outputs at reset values immediately.
